// File: rtl/bcd_text_pkg.sv
// bcd_text_pkg: state encoding and ASCII constants shared by the BCD text writer.
// The suffix states exist only when BCD_TEXT_WRITER_UNIT_MS_EN is defined.
package bcd_text_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
`ifdef BCD_TEXT_WRITER_UNIT_MS_EN
        , S_LOAD_M,
        S_WRITE_M,
        S_LOAD_S,
        S_WRITE_S
`endif
    } state_t;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_M     = 8'h6D;
    localparam logic [7:0] ASCII_S     = 8'h73;
endpackage

// File: rtl/bcd_char_encode.sv
// bcd_char_encode: maps one BCD nibble to ASCII with leading-zero blanking.
module bcd_char_encode import bcd_text_pkg::*; #(
    parameter logic [7:0] CHAR_ZERO  = ASCII_ZERO,
    parameter logic [7:0] CHAR_BLANK = ASCII_SPACE,
    parameter logic [7:0] CHAR_BAD   = ASCII_QMARK
) (
    input  logic [3:0] nibble,
    input  logic       seen,
    input  logic       is_last,
    output logic [7:0] ch,
    output logic       seen_next
);
    // An invalid nibble is nonzero, so it also ends the blanking run.
    assign ch = (nibble > 4'd9) ? CHAR_BAD :
                (nibble == 4'd0 && !seen && !is_last) ? CHAR_BLANK :
                CHAR_ZERO + {4'd0, nibble};
    assign seen_next = seen | (nibble != 4'd0);
endmodule

// File: rtl/bcd_text_writer.sv
// bcd_text_writer: writes a packed BCD value as ASCII text into the OSD text RAM.
// Define BCD_TEXT_WRITER_UNIT_MS_EN to append an "ms" suffix after the digits.
module bcd_text_writer import bcd_text_pkg::*; #(
    parameter int         DECIMAL_DIGITS = 4,
    parameter int         ADDR_WIDTH     = 8,
    parameter logic [7:0] CHAR_ZERO      = ASCII_ZERO,
    parameter logic [7:0] CHAR_BLANK     = ASCII_SPACE,
    parameter logic [7:0] CHAR_BAD       = ASCII_QMARK
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset_n,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    input  logic                        i_DV,
    input  logic [ADDR_WIDTH-1:0]       i_Base_Addr,
    output logic                        o_Wr_En,
    output logic [ADDR_WIDTH-1:0]       o_Wr_Addr,
    output logic [7:0]                  o_Wr_Data,
    input  logic                        i_Wr_Ready,
    output logic                        o_Busy,
    output logic                        o_Done
);
    localparam int KW = DECIMAL_DIGITS > 1 ? $clog2(DECIMAL_DIGITS) : 1;
`ifdef BCD_TEXT_WRITER_UNIT_MS_EN
    localparam state_t S_AFTER_DIGITS = S_LOAD_M;
`else
    localparam state_t S_AFTER_DIGITS = S_DONE;
`endif

    state_t                      state, nxt_state;
    logic [KW-1:0]               k, nxt_k;
    logic                        seen, nxt_seen;
    logic [DECIMAL_DIGITS*4-1:0] bcd_q, nxt_bcd;
    logic [ADDR_WIDTH-1:0]       base_q, nxt_base, nxt_addr, digit_addr;
    logic                        nxt_wr_en, nxt_busy, nxt_done;
    logic [7:0]                  nxt_data, enc_ch;
    logic                        enc_seen;

    assign digit_addr = base_q + ADDR_WIDTH'(DECIMAL_DIGITS - 1 - int'(k));

    bcd_char_encode #(
        .CHAR_ZERO (CHAR_ZERO),
        .CHAR_BLANK(CHAR_BLANK),
        .CHAR_BAD  (CHAR_BAD)
    ) u_enc (
        .nibble   (bcd_q[int'(k)*4 +: 4]),
        .seen     (seen),
        .is_last  (k == '0),
        .ch       (enc_ch),
        .seen_next(enc_seen)
    );

    always_comb begin
        nxt_state = state;
        nxt_k     = k;
        nxt_seen  = seen;
        nxt_bcd   = bcd_q;
        nxt_base  = base_q;
        nxt_wr_en = o_Wr_En;
        nxt_addr  = o_Wr_Addr;
        nxt_data  = o_Wr_Data;
        nxt_busy  = o_Busy;
        nxt_done  = 1'b0;
        case (state)
            S_IDLE: if (i_DV) begin
                nxt_state = S_LOAD;
                nxt_bcd   = i_BCD;
                nxt_base  = i_Base_Addr;
                nxt_seen  = 1'b0;
                nxt_k     = KW'(DECIMAL_DIGITS - 1);
                nxt_busy  = 1'b1;
            end
            S_LOAD: begin
                nxt_state = S_WRITE;
                nxt_wr_en = 1'b1;
                nxt_addr  = digit_addr;
                nxt_data  = enc_ch;
                nxt_seen  = enc_seen;
            end
            S_WRITE: if (i_Wr_Ready) begin
                nxt_wr_en = 1'b0;
                nxt_state = (k != '0) ? S_LOAD : S_AFTER_DIGITS;
                nxt_k     = (k != '0) ? k - 1'b1 : k;
            end
`ifdef BCD_TEXT_WRITER_UNIT_MS_EN
            S_LOAD_M: begin
                nxt_state = S_WRITE_M;
                nxt_wr_en = 1'b1;
                nxt_addr  = base_q + ADDR_WIDTH'(DECIMAL_DIGITS);
                nxt_data  = ASCII_M;
            end
            S_WRITE_M: if (i_Wr_Ready) begin
                nxt_wr_en = 1'b0;
                nxt_state = S_LOAD_S;
            end
            S_LOAD_S: begin
                nxt_state = S_WRITE_S;
                nxt_wr_en = 1'b1;
                nxt_addr  = base_q + ADDR_WIDTH'(DECIMAL_DIGITS + 1);
                nxt_data  = ASCII_S;
            end
            S_WRITE_S: if (i_Wr_Ready) begin
                nxt_wr_en = 1'b0;
                nxt_state = S_DONE;
            end
`endif
            S_DONE: begin
                nxt_state = S_IDLE;
                nxt_done  = 1'b1;
                nxt_busy  = 1'b0;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state     <= S_IDLE;
            k         <= '0;
            seen      <= 1'b0;
            bcd_q     <= '0;
            base_q    <= '0;
            o_Wr_En   <= 1'b0;
            o_Wr_Addr <= '0;
            o_Wr_Data <= '0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
        end else begin
            state     <= nxt_state;
            k         <= nxt_k;
            seen      <= nxt_seen;
            bcd_q     <= nxt_bcd;
            base_q    <= nxt_base;
            o_Wr_En   <= nxt_wr_en;
            o_Wr_Addr <= nxt_addr;
            o_Wr_Data <= nxt_data;
            o_Busy    <= nxt_busy;
            o_Done    <= nxt_done;
        end
    end
endmodule

// File: tb/tb_bcd_text_writer.sv
// tb_bcd_text_writer: directed-vector bench for bcd_text_writer.
// Honours BCD_TEXT_WRITER_UNIT_MS_EN to expect the "ms" suffix.
module tb_bcd_text_writer;
`ifdef BCD_TEXT_WRITER_UNIT_MS_EN
    localparam int NW = 6;
`else
    localparam int NW = 4;
`endif
    localparam int LAT = 2 + 2*NW;

    logic        i_Clock = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic [15:0] i_BCD = '0;
    logic        i_DV = 1'b0;
    logic [7:0]  i_Base_Addr = '0;
    logic        i_Wr_Ready = 1'b1;
    logic        o_Wr_En, o_Busy, o_Done;
    logic [7:0]  o_Wr_Addr, o_Wr_Data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    logic [7:0] wa[$];
    logic [7:0] wd[$];

    bcd_text_writer dut (
        .i_Clock    (i_Clock),
        .i_Reset_n  (i_Reset_n),
        .i_BCD      (i_BCD),
        .i_DV       (i_DV),
        .i_Base_Addr(i_Base_Addr),
        .o_Wr_En    (o_Wr_En),
        .o_Wr_Addr  (o_Wr_Addr),
        .o_Wr_Data  (o_Wr_Data),
        .i_Wr_Ready (i_Wr_Ready),
        .o_Busy     (o_Busy),
        .o_Done     (o_Done)
    );

    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) cyc <= cyc + 1;

    // Writes are logged mid-cycle; a write with ready high is taken at the next edge.
    always @(negedge i_Clock) begin
        if (i_Reset_n && o_Wr_En && i_Wr_Ready) begin
            wa.push_back(o_Wr_Addr);
            wd.push_back(o_Wr_Data);
        end
        if (o_Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_ch(input logic [31:0] txt, input int i);
        return i < 4 ? txt[31-8*i -: 8] : (i == 4 ? 8'h6D : 8'h73);
    endfunction

    task automatic start(input logic [15:0] bcd, input logic [7:0] base, input string tag);
        wa.delete();
        wd.delete();
        @(posedge i_Clock); #1;
        i_BCD = bcd;
        i_Base_Addr = base;
        i_DV = 1'b1;
        dv_cyc = cyc;
        @(posedge i_Clock); #1;
        i_DV = 1'b0;
        i_BCD = 16'h9876;
        i_Base_Addr = 8'h55;
        check({tag, "_busy"}, 32'(o_Busy), 32'd1);
    endtask

    task automatic run(input logic [15:0] bcd, input logic [7:0] base, input logic [31:0] txt,
                       input bit stall, input string tag);
        int d0;
        d0 = done_cnt;
        start(bcd, base, tag);
        if (stall) begin
            @(posedge i_Clock); #1;
            @(posedge i_Clock); #1;
            @(posedge i_Clock); #1;
            i_Wr_Ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
                check($sformatf("%s_hold_en%0d", tag, s), 32'(o_Wr_En), 32'd1);
                check($sformatf("%s_hold_addr%0d", tag, s), 32'(o_Wr_Addr), 32'(8'(base + 8'd1)));
                check($sformatf("%s_hold_data%0d", tag, s), 32'(o_Wr_Data), 32'(exp_ch(txt, 1)));
                @(posedge i_Clock); #1;
                i_DV = (s == 0);
                i_BCD = 16'h1111;
            end
            i_DV = 1'b0;
            i_Wr_Ready = 1'b1;
        end
        for (int i = 0; i < 200 && done_cnt == d0; i++) @(posedge i_Clock);
        #1;
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_lat"}, 32'(done_cyc - dv_cyc), 32'(LAT + (stall ? 3 : 0)));
        check({tag, "_busy_end"}, 32'(o_Busy), 32'd0);
        check({tag, "_nwr"}, 32'(wa.size()), 32'(NW));
        for (int i = 0; i < NW && i < wa.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(8'(base + 8'(i))));
            check($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(exp_ch(txt, i)));
        end
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge i_Clock);
        #1;
        check("rst_wr_en", 32'(o_Wr_En), 32'd0);
        check("rst_addr", 32'(o_Wr_Addr), 32'd0);
        check("rst_data", 32'(o_Wr_Data), 32'd0);
        check("rst_busy", 32'(o_Busy), 32'd0);
        check("rst_done", 32'(o_Done), 32'd0);
        i_Reset_n = 1'b1;

        run(16'h0042, 8'h10, "  42", 1'b0, "v0042");
        run(16'h0000, 8'h20, "   0", 1'b0, "v0000");
        run(16'h1005, 8'h30, "1005", 1'b0, "v1005");
        run(16'h00A3, 8'h40, "  ?3", 1'b0, "v00a3");
        run(16'h0A00, 8'h48, " ?00", 1'b0, "v0a00");
        run(16'h1234, 8'hFE, "1234", 1'b0, "vwrap");
        run(16'h0120, 8'h00, " 120", 1'b0, "v0120");
        run(16'h5678, 8'h60, "5678", 1'b1, "vstall");

        d0 = done_cnt;
        start(16'h1234, 8'h70, "vrst");
        for (int i = 0; i < 50 && wa.size() < 2; i++) @(posedge i_Clock);
        #1;
        @(posedge i_Clock); #1;
        check("vrst_third_en", 32'(o_Wr_En), 32'd1);
        check("vrst_third_addr", 32'(o_Wr_Addr), 32'h72);
        i_Reset_n = 1'b0;
        @(posedge i_Clock); #1;
        check("vrst_wr_en", 32'(o_Wr_En), 32'd0);
        check("vrst_busy", 32'(o_Busy), 32'd0);
        i_Reset_n = 1'b1;
        repeat (20) @(posedge i_Clock);
        #1;
        check("vrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("vrst_nwr", 32'(wa.size()), 32'd2);

        run(16'h0907, 8'h80, " 907", 1'b0, "vafter");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
